// File: rtl/writeback_unit_pkg.sv
// Shared writeback definitions: register-file geometry, the queued/selected
// result record, and a small helper for the x0 "no architectural write" rule.
package writeback_unit_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;

  // One writeback request: destination register plus result data.
  typedef struct packed {
    logic [REG_ADDR_W-1:0]   rd;
    logic [XLEN_DEFAULT-1:0] data;
  } wb_req_t;

  localparam wb_req_t WB_REQ_NONE = '{rd: 5'd0, data: 32'h0000_0000};

  // x0 is hard-wired, so only a non-zero destination is a real write.
  function automatic logic rd_writes(input logic [REG_ADDR_W-1:0] rd);
    return (rd != 5'd0);
  endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Bundle of the writeback unit's result, issue, hazard-query and
// register-file write-port signals. Optional forwarding signals appear
// only when WB_BYPASS_EN is defined.
interface writeback_unit_if #(
  parameter int XLEN           = 32,
  parameter int LSU_FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(LSU_FIFO_DEPTH) + 1;

  logic             alu_valid;
  logic [4:0]       alu_rd;
  logic [XLEN-1:0]  alu_data;
  logic             alu_stall;
  logic             lsu_valid;
  logic             lsu_ready;
  logic [4:0]       lsu_rd;
  logic [XLEN-1:0]  lsu_data;
  logic             issue_valid;
  logic [4:0]       issue_rd;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic             rs1_pending;
  logic             rs2_pending;
  logic             rf_write_enable;
  logic [4:0]       rf_addr_rd;
  logic [XLEN-1:0]  rf_data_rd;
  logic [CNT_W-1:0] fifo_count;
`ifdef WB_BYPASS_EN
  logic             rs1_fwd_valid;
  logic [XLEN-1:0]  rs1_fwd_data;
  logic             rs2_fwd_valid;
  logic [XLEN-1:0]  rs2_fwd_data;
`endif

  // Writeback unit side.
  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           issue_valid, issue_rd, rs1_addr, rs2_addr,
    output alu_stall, lsu_ready, rs1_pending, rs2_pending,
           rf_write_enable, rf_addr_rd, rf_data_rd, fifo_count
`ifdef WB_BYPASS_EN
    , output rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data
`endif
  );

  // Pipeline / register-file side.
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           issue_valid, issue_rd, rs1_addr, rs2_addr,
    input  alu_stall, lsu_ready, rs1_pending, rs2_pending,
           rf_write_enable, rf_addr_rd, rf_data_rd, fifo_count
`ifdef WB_BYPASS_EN
    , input rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data
`endif
  );

endinterface

// File: rtl/writeback_unit_fifo.sv
// Circular queue of LSU writeback requests. Registered storage only, so an
// entry pushed into an empty queue is visible at the head one cycle later.
module writeback_unit_fifo
  import writeback_unit_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  wb_req_t          push_data,
  input  logic             pop,
  output wb_req_t          pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  wb_req_t          mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty     = (count_r == {CNT_W{1'b0}});
  assign full      = (count_r == CNT_W'(DEPTH));
  assign pop_ok_s  = pop && !empty;
  // A pop frees the slot, so a full queue may still accept in the same cycle.
  assign push_ok_s = push && (!full || pop_ok_s);
  assign pop_data  = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Entry storage; contents are don't-care until counted as occupied.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally (power-of-two depth); occupancy tracks push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write-port producer: arbitrates ALU results against queued
// LSU results (with a starvation guard for the LSU), registers one write per
// cycle onto the rf_* port and tracks outstanding writes for hazard checks.
// Optional macro WB_BYPASS_EN adds forwarding from the rf_* stage and clears
// scoreboard bits one edge earlier.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int XLEN           = XLEN_DEFAULT,
  parameter int LSU_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT   = 8
) (
  input logic              clk,
  input logic              rst_n,
  writeback_unit_if.slave  wb
);

  localparam int CNT_W    = $clog2(LSU_FIFO_DEPTH) + 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  wb_req_t               lsu_req_s;
  wb_req_t               alu_req_s;
  wb_req_t               fifo_head_s;
  wb_req_t               win_req_s;
  logic                  win_valid_s;
  logic                  fifo_push_s;
  logic                  fifo_pop_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [CNT_W-1:0]      fifo_count_s;
  logic                  alu_stall_s;
  logic [STARVE_W-1:0]   starve_r;
  logic [STARVE_W-1:0]   starve_next_s;
  logic [NUM_REGS-1:0]   pending_r;
  logic [NUM_REGS-1:0]   pending_next_s;
  logic                  clr_en_s;
  logic [REG_ADDR_W-1:0] clr_addr_s;
  logic                  rf_wen_r;
  logic [REG_ADDR_W-1:0] rf_addr_r;
  logic [XLEN-1:0]       rf_data_r;

  assign lsu_req_s   = '{rd: wb.lsu_rd, data: wb.lsu_data};
  assign alu_req_s   = '{rd: wb.alu_rd, data: wb.alu_data};
  assign fifo_push_s = wb.lsu_valid && !fifo_full_s;

  writeback_unit_fifo #(.DEPTH(LSU_FIFO_DEPTH)) u_wb_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push_s),
    .push_data (lsu_req_s),
    .pop       (fifo_pop_s),
    .pop_data  (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Arbitration: forced LSU slot when starved, else ALU, else queued LSU.
  always_comb begin
    win_valid_s   = 1'b0;
    win_req_s     = WB_REQ_NONE;
    fifo_pop_s    = 1'b0;
    alu_stall_s   = 1'b0;
    starve_next_s = {STARVE_W{1'b0}};
    if ((starve_r >= STARVE_W'(STARVE_LIMIT)) && !fifo_empty_s) begin
      win_valid_s = 1'b1;
      win_req_s   = fifo_head_s;
      fifo_pop_s  = 1'b1;
      alu_stall_s = wb.alu_valid;
    end else if (wb.alu_valid) begin
      win_valid_s = 1'b1;
      win_req_s   = alu_req_s;
      if (fifo_empty_s) begin
        starve_next_s = {STARVE_W{1'b0}};
      end else if (starve_r >= STARVE_W'(STARVE_LIMIT)) begin
        starve_next_s = starve_r;
      end else begin
        starve_next_s = starve_r + STARVE_W'(1);
      end
    end else if (!fifo_empty_s) begin
      win_valid_s = 1'b1;
      win_req_s   = fifo_head_s;
      fifo_pop_s  = 1'b1;
    end else begin
      win_valid_s = 1'b0;
    end
  end

  // Scoreboard clear point: the registering edge with forwarding, otherwise
  // the commit edge when the register file actually takes the write.
`ifdef WB_BYPASS_EN
  assign clr_en_s   = win_valid_s && rd_writes(win_req_s.rd);
  assign clr_addr_s = win_req_s.rd;
`else
  assign clr_en_s   = rf_wen_r;
  assign clr_addr_s = rf_addr_r;
`endif

  // Next scoreboard: a set on issue overrides a same-edge clear; x0 never pends.
  always_comb begin
    pending_next_s = pending_r;
    for (int i = 0; i < NUM_REGS; i++) begin
      pending_next_s[i] = (wb.issue_valid && (wb.issue_rd == REG_ADDR_W'(i))) ||
                          (pending_r[i] && !(clr_en_s && (clr_addr_s == REG_ADDR_W'(i))));
    end
    pending_next_s[0] = 1'b0;
  end

  // Output write-port registers, starvation counter and scoreboard state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_wen_r  <= 1'b0;
      rf_addr_r <= {REG_ADDR_W{1'b0}};
      rf_data_r <= {XLEN{1'b0}};
      starve_r  <= {STARVE_W{1'b0}};
      pending_r <= {NUM_REGS{1'b0}};
    end else begin
      rf_wen_r  <= win_valid_s && rd_writes(win_req_s.rd);
      rf_addr_r <= win_valid_s ? win_req_s.rd : {REG_ADDR_W{1'b0}};
      rf_data_r <= win_valid_s ? XLEN'(win_req_s.data) : {XLEN{1'b0}};
      starve_r  <= starve_next_s;
      pending_r <= pending_next_s;
    end
  end

  assign wb.alu_stall       = alu_stall_s;
  assign wb.lsu_ready       = !fifo_full_s;
  assign wb.fifo_count      = fifo_count_s;
  assign wb.rs1_pending     = pending_r[wb.rs1_addr];
  assign wb.rs2_pending     = pending_r[wb.rs2_addr];
  assign wb.rf_write_enable = rf_wen_r;
  assign wb.rf_addr_rd      = rf_addr_r;
  assign wb.rf_data_rd      = rf_data_r;

`ifdef WB_BYPASS_EN
  assign wb.rs1_fwd_valid = rf_wen_r && (rf_addr_r == wb.rs1_addr) && rd_writes(wb.rs1_addr);
  assign wb.rs1_fwd_data  = rf_data_r;
  assign wb.rs2_fwd_valid = rf_wen_r && (rf_addr_r == wb.rs2_addr) && rd_writes(wb.rs2_addr);
  assign wb.rs2_fwd_data  = rf_data_r;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: a vector table for single-cycle
// behaviour plus hand-written sequences for queue-full back-pressure,
// starvation, mid-run reset and (when built with WB_BYPASS_EN) forwarding.
module tb_writeback_unit;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  writeback_unit_if #(.XLEN(32), .LSU_FIFO_DEPTH(4)) wb ();

  writeback_unit #(.XLEN(32), .LSU_FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decode must never issue to a register that already has a write in flight.
  always @(posedge clk) begin
    if (rst_n && wb.issue_valid && (wb.issue_rd != 5'd0)) begin
      assert (!dut.pending_r[wb.issue_rd])
        else $error("FAIL waw_issue: rd %0d already pending", wb.issue_rd);
    end
  end

`ifdef WB_BYPASS_EN
  localparam logic NB = 1'b0;
`else
  localparam logic NB = 1'b1;
`endif

  typedef struct {
    logic        alu_v;  logic [4:0] alu_rd; logic [31:0] alu_d;
    logic        lsu_v;  logic [4:0] lsu_rd; logic [31:0] lsu_d;
    logic        iss_v;  logic [4:0] iss_rd;
    logic [4:0]  rs1;    logic [4:0] rs2;
    logic        e_stall; logic e_ready; logic [2:0] e_count; logic e_p1; logic e_p2;
    logic        e_wen;  logic [4:0] e_addr; logic [31:0] e_data;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic iv, input logic [4:0] ird);
    wb.alu_valid = av;  wb.alu_rd = ard; wb.alu_data = ad;
    wb.lsu_valid = lv;  wb.lsu_rd = lrd; wb.lsu_data = ld;
    wb.issue_valid = iv; wb.issue_rd = ird;
  endtask

  initial begin
    int k;
    logic exp_stall;
    n_pass = 0;
    n_total = 0;

    //        alu            lsu             issue   rs1   rs2   stall rdy cnt p1 p2  wen addr data
    vecs[0]  = '{0,0,0,        0,0,0,          0,0,    0,0,  0,1,3'd0,0,0,   0,0,0};
    vecs[1]  = '{0,0,0,        0,0,0,          1,5,    5,0,  0,1,3'd0,0,0,   0,0,0};
    vecs[2]  = '{1,5,32'h1234, 0,0,0,          0,0,    5,0,  0,1,3'd0,1,0,   1,5,32'h1234};
    vecs[3]  = '{0,0,0,        0,0,0,          0,0,    5,0,  0,1,3'd0,NB,0,  0,0,0};
    vecs[4]  = '{0,0,0,        0,0,0,          0,0,    5,0,  0,1,3'd0,0,0,   0,0,0};
    vecs[5]  = '{1,0,32'hFFFF, 0,0,0,          0,0,    5,0,  0,1,3'd0,0,0,   0,0,0};
    vecs[6]  = '{0,0,0,        1,3,32'hAA,     1,3,    0,3,  0,1,3'd0,0,0,   0,0,0};
    vecs[7]  = '{0,0,0,        0,0,0,          0,0,    0,3,  0,1,3'd1,0,1,   1,3,32'hAA};
    vecs[8]  = '{0,0,0,        0,0,0,          0,0,    0,3,  0,1,3'd0,0,NB,  0,0,0};
    vecs[9]  = '{0,0,0,        0,0,0,          0,0,    0,3,  0,1,3'd0,0,0,   0,0,0};
    vecs[10] = '{1,6,32'h66,   1,4,32'h44,     0,0,    0,0,  0,1,3'd0,0,0,   1,6,32'h66};
    vecs[11] = '{0,0,0,        0,0,0,          0,0,    0,0,  0,1,3'd1,0,0,   1,4,32'h44};
    vecs[12] = '{1,8,32'h88,   0,0,0,          0,0,    0,0,  0,1,3'd0,0,0,   1,8,32'h88};

    // Reset and idle state.
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    wb.rs1_addr = 5'd0;
    wb.rs2_addr = 5'd0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_wen",   32'(wb.rf_write_enable), 32'd0);
    chk("rst_addr",  32'(wb.rf_addr_rd), 32'd0);
    chk("rst_data",  wb.rf_data_rd, 32'd0);
    chk("rst_count", 32'(wb.fifo_count), 32'd0);
    chk("rst_ready", 32'(wb.lsu_ready), 32'd1);
    chk("rst_stall", 32'(wb.alu_stall), 32'd0);
    for (int r = 0; r < 32; r++) begin
      wb.rs1_addr = 5'(r);
      wb.rs2_addr = 5'(31 - r);
      #1;
      chk($sformatf("rst_pend1_r%0d", r), 32'(wb.rs1_pending), 32'd0);
      chk($sformatf("rst_pend2_r%0d", r), 32'(wb.rs2_pending), 32'd0);
    end
    step();

    // Vector table.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].alu_v, vecs[i].alu_rd, vecs[i].alu_d,
            vecs[i].lsu_v, vecs[i].lsu_rd, vecs[i].lsu_d,
            vecs[i].iss_v, vecs[i].iss_rd);
      wb.rs1_addr = vecs[i].rs1;
      wb.rs2_addr = vecs[i].rs2;
      #1;
      chk($sformatf("v%0d_stall", i), 32'(wb.alu_stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d_ready", i), 32'(wb.lsu_ready), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d_count", i), 32'(wb.fifo_count), 32'(vecs[i].e_count));
      chk($sformatf("v%0d_pend1", i), 32'(wb.rs1_pending), 32'(vecs[i].e_p1));
      chk($sformatf("v%0d_pend2", i), 32'(wb.rs2_pending), 32'(vecs[i].e_p2));
      step();
      chk($sformatf("v%0d_wen", i), 32'(wb.rf_write_enable), 32'(vecs[i].e_wen));
      if (vecs[i].e_wen) begin
        chk($sformatf("v%0d_addr", i), 32'(wb.rf_addr_rd), 32'(vecs[i].e_addr));
        chk($sformatf("v%0d_data", i), wb.rf_data_rd, vecs[i].e_data);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    wb.rs1_addr = 5'd0;
    wb.rs2_addr = 5'd0;
    step();

    // Queue fill: ALU busy with x0 results, LSU pushes rd 1..5, 5th held.
    for (int i = 1; i <= 7; i++) begin
      k = (i <= 5) ? i : 5;
      drive(1, 0, 0, 1, 5'(k), 32'h100 + 32'(k), 0, 0);
      #1;
      chk($sformatf("full%0d_ready", i), 32'(wb.lsu_ready), (i <= 4) ? 32'd1 : 32'd0);
      chk($sformatf("full%0d_count", i), 32'(wb.fifo_count), (i <= 4) ? 32'(i - 1) : 32'd4);
      step();
      chk($sformatf("full%0d_wen", i), 32'(wb.rf_write_enable), 32'd0);
    end
    // Drain: held rd5 enters once a slot frees; nothing is lost.
    for (int j = 0; j < 5; j++) begin
      if (j < 2) drive(0, 0, 0, 1, 5'd5, 32'h105, 0, 0);
      else       drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk($sformatf("drain%0d_ready", j), 32'(wb.lsu_ready), (j == 0) ? 32'd0 : 32'd1);
      chk($sformatf("drain%0d_count", j), 32'(wb.fifo_count),
          (j == 0) ? 32'd4 : (j == 1) ? 32'd3 : 32'(5 - j));
      step();
      chk($sformatf("drain%0d_wen", j), 32'(wb.rf_write_enable), 32'd1);
      chk($sformatf("drain%0d_addr", j), 32'(wb.rf_addr_rd), 32'(j + 1));
      chk($sformatf("drain%0d_data", j), wb.rf_data_rd, 32'h101 + 32'(j));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("drain_empty", 32'(wb.fifo_count), 32'd0);
    step();
    chk("drain_idle_wen", 32'(wb.rf_write_enable), 32'd0);

    // Starvation: rd7 queued while ALU stays busy; 9th cycle forces the LSU.
    drive(1, 0, 0, 1, 5'd7, 32'h77, 0, 0);
    step();
    k = 0;
    for (int c = 0; c < 20; c++) begin
      drive(1, 5'(16 + (k % 8)), 32'hA000 + 32'(k), 0, 0, 0, 0, 0);
      #1;
      exp_stall = (c == 8);
      chk($sformatf("starve%0d_stall", c), 32'(wb.alu_stall), 32'(exp_stall));
      step();
      chk($sformatf("starve%0d_wen", c), 32'(wb.rf_write_enable), 32'd1);
      chk($sformatf("starve%0d_addr", c), 32'(wb.rf_addr_rd),
          exp_stall ? 32'd7 : 32'(16 + (k % 8)));
      chk($sformatf("starve%0d_data", c), wb.rf_data_rd,
          exp_stall ? 32'h77 : 32'hA000 + 32'(k));
      if (!exp_stall) k++;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Reset mid-operation discards queued results and the scoreboard.
    drive(1, 0, 0, 1, 5'd1, 32'h201, 1, 5'd9);
    step();
    drive(1, 0, 0, 1, 5'd2, 32'h202, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    wb.rs1_addr = 5'd9;
    #1;
    chk("mid_count_pre", 32'(wb.fifo_count), 32'd2);
    chk("mid_pend_pre",  32'(wb.rs1_pending), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("mid_count", 32'(wb.fifo_count), 32'd0);
    chk("mid_ready", 32'(wb.lsu_ready), 32'd1);
    chk("mid_pend",  32'(wb.rs1_pending), 32'd0);
    chk("mid_wen",   32'(wb.rf_write_enable), 32'd0);
    step();
    chk("mid_wen_after",   32'(wb.rf_write_enable), 32'd0);
    chk("mid_count_after", 32'(wb.fifo_count), 32'd0);

    // Commit cycle of rd9: forwarding when enabled, pending otherwise.
    wb.rs1_addr = 5'd0;
    wb.rs2_addr = 5'd0;
    drive(0, 0, 0, 0, 0, 0, 1, 5'd9);
    step();
    drive(1, 5'd9, 32'hABCD, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    wb.rs2_addr = 5'd9;
    #1;
    chk("byp_wen",  32'(wb.rf_write_enable), 32'd1);
    chk("byp_addr", 32'(wb.rf_addr_rd), 32'd9);
    chk("byp_data", wb.rf_data_rd, 32'hABCD);
`ifdef WB_BYPASS_EN
    chk("byp_fwd2_valid", 32'(wb.rs2_fwd_valid), 32'd1);
    chk("byp_fwd2_data",  wb.rs2_fwd_data, 32'hABCD);
    chk("byp_fwd1_valid", 32'(wb.rs1_fwd_valid), 32'd0);
    chk("byp_pend2",      32'(wb.rs2_pending), 32'd0);
`else
    chk("byp_pend2",      32'(wb.rs2_pending), 32'd1);
`endif
    step();
    chk("byp_pend2_after", 32'(wb.rs2_pending), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Producer side of the register-file write port in the pipelined core.
- Merges writeback results from the ALU path and the variable-latency load/store unit (LSU), and queues LSU results in a small FIFO.
- Drives one registered write per cycle into the register file's write_enable/addr_rd/data_rd port.
- Keeps a pending-write scoreboard so decode can detect RAW hazards on rs1/rs2.

Parameters:
- XLEN, 32, data width of results and register-file write data
- LSU_FIFO_DEPTH, 4, LSU result queue entries (power of two, >=2)
- STARVE_LIMIT, 8, consecutive ALU-won cycles with a non-empty FIFO before the LSU is forced a slot

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- alu_valid  in  1  ALU result present
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- alu_stall  out  1  ALU result not accepted this cycle; ALU holds rd/data
- lsu_valid  in  1  load result present
- lsu_ready  out  1  FIFO can accept (not full)
- lsu_rd  in  5  load destination register
- lsu_data  in  XLEN  load data
- issue_valid  in  1  an instruction writing issue_rd is issued this cycle
- issue_rd  in  5  destination of the issued instruction
- rs1_addr, rs2_addr  in  5 each  decode source registers
- rs1_pending, rs2_pending  out  1 each  source has an outstanding write (combinational from state)
- rf_write_enable  out  1  register-file write enable (registered)
- rf_addr_rd  out  5  register-file write address (registered)
- rf_data_rd  out  XLEN  register-file write data (registered)
- fifo_count  out  clog2(LSU_FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n low at a clock edge): FIFO empty, fifo_count=0, scoreboard all 0, starvation counter 0. Outputs rf_write_enable=0, rf_addr_rd=0, rf_data_rd=0, alu_stall=0. lsu_ready=1 from the first cycle after reset. Reset mid-operation discards queued LSU results.
- LSU input: push on lsu_valid && lsu_ready; lsu_ready = (fifo_count != LSU_FIFO_DEPTH). A full-FIFO push is not taken; the LSU holds its data and nothing is dropped.
- FIFO: circular buffer; pointers wrap modulo LSU_FIFO_DEPTH. A push and a pop in the same cycle are both allowed when the FIFO is full (pop frees the slot, count unchanged). A push into an empty FIFO is not poppable until the next cycle (no fall-through).
- Per-cycle selection of the write for the next cycle:
  1. Starvation counter >= STARVE_LIMIT and FIFO non-empty: pop the FIFO head; alu_stall=1 if alu_valid; counter cleared.
  2. Else if alu_valid: take the ALU result; alu_stall=0; counter increments if the FIFO is non-empty (saturating), otherwise clears.
  3. Else if FIFO non-empty: pop; counter cleared.
  4. Else: no write.
- Write port latency: the winner is registered onto rf_* at the edge after selection, and the register file commits it at the following edge.
- rd==0: the result is consumed (the pop or accept still happens), but rf_write_enable stays 0 for that slot.
- Scoreboard: pending[31:0], bit 0 hard-wired to 0.
  - Set: at the edge where issue_valid=1 and issue_rd!=0.
  - Clear: at the edge where rf_write_enable=1 (the commit edge), for rf_addr_rd.
  - Same-edge set and clear of the same register: set wins.
  - issue_valid to a register already pending is illegal (decode stalls on WAW); the bench asserts against it.
- Query: rs1_pending = pending[rs1_addr], rs2_pending = pending[rs2_addr].

Optional Feature:
- Macro: WB_BYPASS_EN
- Defined:
  - Adds outputs rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data.
  - rsN_fwd_valid = rf_write_enable && (rf_addr_rd == rsN_addr) && (rsN_addr != 0), with rsN_fwd_data = rf_data_rd.
  - The scoreboard clears one edge earlier (when the write is registered onto rf_*), so decode takes forwarded data in the commit cycle.
- Undefined: no forward ports; the scoreboard clears at the commit edge as above.

Decomposition:
- Shared core package: XLEN default, REG_ADDR_W=5, NUM_REGS=32, and a wb_req_t struct {rd, data} used for the FIFO entries and the arbiter result.
- One natural sub-module: wb_fifo (parameterised circular FIFO: push/pop/full/empty/count).
- Arbitration, scoreboard and output registers stay in writeback_unit.

Test Plan:
- Reset then idle -> rf_write_enable=0, fifo_count=0, lsu_ready=1, pending all 0.
- issue x5; ALU result rd=5, data 0x1234 -> rf_write_enable=1, rf_addr_rd=5, rf_data_rd=0x1234 one cycle later; rs1_addr=5 pending until the commit edge, then 0.
- 5 LSU pushes (rd 1..5) with no pops, DEPTH=4 -> lsu_ready=0 after 4 pushes; the 5th is held; count stays 4 until a pop frees a slot.
- alu_valid held high for 20 cycles with the FIFO holding rd=7 -> after 8 ALU writes, one cycle with alu_stall=1 writes rd=7; ALU writes then resume.
- ALU result rd=0, data 0xFFFF -> rf_write_enable stays 0; no stall; scoreboard unchanged.
- WB_BYPASS_EN: write rd=9, data 0xABCD on rf_*, rs2_addr=9 -> rs2_fwd_valid=1, rs2_fwd_data=0xABCD, rs2_pending=0 in the same cycle.
